move_sched: RTL and testbench
=============================

Name: move_sched

Overview:
- Movement scheduler for the player sprite.
- Arbitrates direction requests from the PS/2 keyboard (level) and the Bluetooth UART decoder (byte pulses).
- Generates the frame-rate tick and drives the shared dir/ena inputs of the X/Y position updaters.
- Freezes movement after a collision.

Parameters:
- TICK_W, 21, width of the free-running tick divider; tick fires when the counter wraps (2^TICK_W clk cycles).
- BT_HOLD, 8, ticks a single Bluetooth command keeps moving the sprite.
- FREEZE_TICKS, 30, ticks movement is frozen after a collision.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- kbd_dir  in  4  keyboard direction level; 1000=left, 0001=right, 0100=up, 0010=down
- bt_dir  in  4  Bluetooth direction byte, decoded to the same encoding
- bt_valid  in  1  one-cycle strobe, bt_dir valid
- collide  in  1  level from the object/collision checker
- tick  out  1  one-clk pulse per frame, to the position updaters
- dir  out  4  granted direction, 0000 = none
- ena  out  1  1 = freeze (updaters move only when ena=0)
- owner  out  2  00 none, 01 keyboard, 10 Bluetooth, 11 frozen

Behaviour:
- Reset values: tick=0, dir=0000, ena=0, owner=00. Divider=0, bt pending cleared, state IDLE.
- Tick: TICK_W-bit counter increments every clk. tick=1 for exactly the cycle the counter equals all-ones, so the period is 2^TICK_W.
- Request validity: a request counts only if its direction is exactly one-hot. 0000 or multi-hot = no request.
- bt capture:
  - On bt_valid with a valid bt_dir, latch bt_cmd and set bt_pend, on any clk.
  - A later valid strobe overwrites bt_cmd.
  - An invalid bt_dir is ignored and does not clear bt_pend.
- State timing: the FSM advances only on cycles where tick=1. dir/ena/owner are registered and change only on those cycles, so the updaters see stable values across a whole frame.
- States (evaluated on tick):
  - IDLE
    - collide → FREEZE.
    - Else valid kbd_dir → KBD.
    - Else bt_pend → BT: load hold counter with BT_HOLD, clear bt_pend.
    - Otherwise stay; dir=0000.
  - KBD
    - collide → FREEZE.
    - kbd_dir valid → dir=kbd_dir (a direction change is followed the same tick).
    - kbd_dir invalid → IDLE, dir=0000.
    - Keyboard owns the resource; bt_pend is kept but not served.
  - BT
    - collide → FREEZE.
    - Valid kbd_dir preempts → KBD; the remaining hold is discarded.
    - bt_pend set → reload hold=BT_HOLD, dir=bt_cmd, clear bt_pend.
    - Else decrement hold; hold reaching 0 → IDLE, dir=0000.
  - FREEZE
    - On entry: ena=1, dir=0000, owner=11, freeze counter=FREEZE_TICKS, bt_pend cleared.
    - Decrement each tick. At 0 → IDLE, ena=0.
    - collide still high at expiry → re-enter FREEZE, counter reloaded.
- Priorities:
  - collide beats both sources.
  - Keyboard beats Bluetooth.
  - bt_valid arriving on the same clk as tick is captured and served on the next tick, not the current one.
- Counter widths: $clog2(max(BT_HOLD,FREEZE_TICKS)+1). BT_HOLD=0 or FREEZE_TICKS=0 means a single-tick hold/freeze.
- rst mid-frame: everything returns to reset values immediately (asynchronous) and the divider restarts from 0.

Optional Feature:
- Macro: REVERSE_GAP_EN.
- Defined:
  - In KBD or BT, a newly granted direction that is the exact opposite of the current dir (left↔right, up↔down) first outputs dir=0000 for one tick, then the new direction on the next tick.
  - Owner and hold counting are unaffected, except that the gap tick does consume one hold count.
- Undefined: reversal is applied on the same tick.

Decomposition:
- Package move_pkg holds:
  - direction constants DIR_L=4'b1000, DIR_R=4'b0001, DIR_U=4'b0100, DIR_D=4'b0010, DIR_NONE;
  - the state enum {IDLE, KBD, BT, FREEZE};
  - owner codes.
- Natural sub-module: tick_gen (TICK_W counter with wrap pulse), reusable by other frame-rate blocks.

Test Plan (TICK_W=4, BT_HOLD=3, FREEZE_TICKS=2):
- Reset, then idle 64 clk → tick pulses every 16 clk; dir=0000, ena=0, owner=00 throughout.
- kbd_dir=1000 held 3 ticks, then 0001 for 1 tick, then 0000 → dir 1000,1000,1000,0001, then 0000 on the following tick; owner 01 then 00.
  - With REVERSE_GAP_EN: 1000,1000,1000,0000,0001.
- bt_valid pulse with bt_dir=0100, no keyboard → dir=0100 for 4 ticks (grant + 3 hold), then 0000, owner 10→00.
  - Invalid bt_dir=0110 alone → no movement.
- BT active (dir=0010), kbd_dir=0001 asserted → next tick dir=0001, owner=01.
  - After kbd release, BT does not resume unless a new bt_valid arrives.
- collide pulse during KBD → next tick ena=1, dir=0000, owner=11 for 3 ticks (entry + 2), then ena=0.
  - collide held high → freeze persists.
- Assert rst mid-BT-hold → outputs reset immediately; after release, divider restarts and the first tick comes 16 clk later.

Source files
------------

// File: rtl/move_sched_pkg.sv
// Shared definitions for the player-sprite movement scheduler:
// direction codes, scheduler states, owner codes and direction helpers.
package move_pkg;

    localparam logic [3:0] DIR_L    = 4'b1000;
    localparam logic [3:0] DIR_R    = 4'b0001;
    localparam logic [3:0] DIR_U    = 4'b0100;
    localparam logic [3:0] DIR_D    = 4'b0010;
    localparam logic [3:0] DIR_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KBD    = 2'd1,
        BT     = 2'd2,
        FREEZE = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_KBD  = 2'b01;
    localparam logic [1:0] OWN_BT   = 2'b10;
    localparam logic [1:0] OWN_FRZ  = 2'b11;

    function automatic logic dir_valid(input logic [3:0] d);
        return (d == DIR_L) || (d == DIR_R) || (d == DIR_U) || (d == DIR_D);
    endfunction

    // Bit reversal swaps L<->R and U<->D; NONE maps to NONE.
    function automatic logic [3:0] dir_opposite(input logic [3:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction

endpackage

// File: rtl/move_sched_if.sv
// Direction request / grant bundle between the input decoders, the
// scheduler and the X/Y position updaters.
interface move_sched_if;
    logic [3:0] kbd_dir;
    logic [3:0] bt_dir;
    logic       bt_valid;
    logic       collide;
    logic       tick;
    logic [3:0] dir;
    logic       ena;
    logic [1:0] owner;

    modport master (
        output kbd_dir, bt_dir, bt_valid, collide,
        input  tick, dir, ena, owner
    );

    modport slave (
        input  kbd_dir, bt_dir, bt_valid, collide,
        output tick, dir, ena, owner
    );
endinterface

// File: rtl/move_sched_tick_gen.sv
// Free-running W-bit divider; tick is high for the one cycle the counter is
// all-ones, giving a period of 2^W clk cycles.
module tick_gen #(
    parameter int W = 21
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    // One count short of wrap: tick is registered so it lines up with all-ones.
    localparam logic [W-1:0] PRE_WRAP = ~(W'(1));

    logic [W-1:0] cnt_r;

    // Divider and registered wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_r <= cnt_r + W'(1);
            tick  <= (cnt_r == PRE_WRAP);
        end
    end
endmodule

// File: rtl/move_sched.sv
// Player-sprite movement scheduler: arbitrates keyboard and Bluetooth
// requests once per frame tick. Optional macro REVERSE_GAP_EN inserts a
// one-frame stop before a direct reversal.
module move_sched
    import move_pkg::*;
#(
    parameter int TICK_W       = 21,
    parameter int BT_HOLD      = 8,
    parameter int FREEZE_TICKS = 30
) (
    input logic         clk,
    input logic         rst,
    move_sched_if.slave bus
);
    localparam int CMAX = (BT_HOLD > FREEZE_TICKS) ? BT_HOLD : FREEZE_TICKS;
    localparam int CW   = (CMAX < 1) ? 1 : $clog2(CMAX + 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(BT_HOLD);
    localparam logic [CW-1:0] FRZ_LD  = CW'(FREEZE_TICKS);

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [3:0]    dir_r, dir_s;
    logic          ena_r, ena_s;
    logic [1:0]    owner_r, owner_s;
    logic [3:0]    bt_act_r, bt_act_s;
    logic [3:0]    bt_cmd_r;
    logic          bt_pend_r;
    logic          bt_clr_s;
    logic          tick_s;
    logic          kbd_ok_s;
    logic [3:0]    kbd_grant_s;
    logic [3:0]    bt_grant_s;

    tick_gen #(.W(TICK_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    assign kbd_ok_s = dir_valid(bus.kbd_dir);

`ifdef REVERSE_GAP_EN
    assign kbd_grant_s = (bus.kbd_dir == dir_opposite(dir_r)) ? DIR_NONE : bus.kbd_dir;
    assign bt_grant_s  = (bt_cmd_r    == dir_opposite(dir_r)) ? DIR_NONE : bt_cmd_r;
`else
    assign kbd_grant_s = bus.kbd_dir;
    assign bt_grant_s  = bt_cmd_r;
`endif

    // Next-frame state and outputs; only committed on tick cycles.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        dir_s    = dir_r;
        ena_s    = ena_r;
        owner_s  = owner_r;
        bt_act_s = bt_act_r;
        bt_clr_s = 1'b0;
        if (bus.collide && (state_r != FREEZE)) begin
            state_s  = FREEZE;
            cnt_s    = FRZ_LD;
            dir_s    = DIR_NONE;
            ena_s    = 1'b1;
            owner_s  = OWN_FRZ;
            bt_clr_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (kbd_ok_s) begin
                        state_s = KBD;
                        dir_s   = bus.kbd_dir;
                        owner_s = OWN_KBD;
                    end else if (bt_pend_r) begin
                        state_s  = BT;
                        cnt_s    = HOLD_LD;
                        dir_s    = bt_cmd_r;
                        bt_act_s = bt_cmd_r;
                        owner_s  = OWN_BT;
                        bt_clr_s = 1'b1;
                    end else begin
                        dir_s = DIR_NONE;
                    end
                end
                KBD: begin
                    if (kbd_ok_s) begin
                        dir_s = kbd_grant_s;
                    end else begin
                        state_s = IDLE;
                        dir_s   = DIR_NONE;
                        owner_s = OWN_NONE;
                    end
                end
                BT: begin
                    if (kbd_ok_s) begin
                        state_s = KBD;
                        dir_s   = kbd_grant_s;
                        owner_s = OWN_KBD;
                    end else if (bt_pend_r) begin
                        cnt_s    = HOLD_LD;
                        dir_s    = bt_grant_s;
                        bt_act_s = bt_cmd_r;
                        bt_clr_s = 1'b1;
                    end else if (cnt_r == '0) begin
                        state_s = IDLE;
                        dir_s   = DIR_NONE;
                        owner_s = OWN_NONE;
                    end else begin
                        // bt_act_r restores the direction after a reversal gap.
                        cnt_s = cnt_r - CW'(1);
                        dir_s = bt_act_r;
                    end
                end
                FREEZE: begin
                    if (cnt_r != '0) begin
                        cnt_s = cnt_r - CW'(1);
                    end else if (bus.collide) begin
                        cnt_s    = FRZ_LD;
                        bt_clr_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                        ena_s   = 1'b0;
                        owner_s = OWN_NONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                    dir_s   = DIR_NONE;
                    ena_s   = 1'b0;
                    owner_s = OWN_NONE;
                end
            endcase
        end
    end

    // Frame-rate state register; outputs stay stable across a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            dir_r    <= DIR_NONE;
            ena_r    <= 1'b0;
            owner_r  <= OWN_NONE;
            bt_act_r <= DIR_NONE;
        end else if (tick_s) begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            dir_r    <= dir_s;
            ena_r    <= ena_s;
            owner_r  <= owner_s;
            bt_act_r <= bt_act_s;
        end
    end

    // Bluetooth capture on any clk; a same-cycle strobe wins over the frame's clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bt_cmd_r  <= DIR_NONE;
            bt_pend_r <= 1'b0;
        end else if (bus.bt_valid && dir_valid(bus.bt_dir)) begin
            bt_cmd_r  <= bus.bt_dir;
            bt_pend_r <= 1'b1;
        end else if (tick_s && bt_clr_s) begin
            bt_pend_r <= 1'b0;
        end
    end

    assign bus.tick  = tick_s;
    assign bus.dir   = dir_r;
    assign bus.ena   = ena_r;
    assign bus.owner = owner_r;
endmodule

// File: tb/tb_move_sched.sv
// Self-checking bench for move_sched: directed frame scenarios plus random
// traffic compared every clk against a frame-level behavioural model.
module tb_move_sched;
    localparam int TW  = 4;
    localparam int BH  = 3;
    localparam int FT  = 2;
    localparam int PER = 2 ** TW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    move_sched_if bus();

    move_sched #(.TICK_W(TW), .BT_HOLD(BH), .FREEZE_TICKS(FT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: who owns the sprite (0 none,1 kbd,2 bt,3 frozen) and
    // how many further frames the current BT hold / freeze lasts.
    int         m_cnt, m_owner, m_left;
    logic [3:0] m_dir, m_cmd, m_btdir;
    logic       m_ena, m_pend;
    bit         framed;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic bit onehot(input logic [3:0] d);
        return $countones(d) == 1;
    endfunction

    function automatic logic [3:0] rev_gap(input logic [3:0] nd);
`ifdef REVERSE_GAP_EN
        if ((nd == 4'b1000 && m_dir == 4'b0001) || (nd == 4'b0001 && m_dir == 4'b1000) ||
            (nd == 4'b0100 && m_dir == 4'b0010) || (nd == 4'b0010 && m_dir == 4'b0100))
            return 4'b0000;
`endif
        return nd;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_owner = 0; m_left = 0;
        m_dir = 4'b0000; m_cmd = 4'b0000; m_btdir = 4'b0000;
        m_ena = 1'b0; m_pend = 1'b0;
    endtask

    task automatic frame_update(output bit clr);
        logic [3:0] k;
        k   = bus.kbd_dir;
        clr = 1'b0;
        if (m_owner != 3 && bus.collide) begin
            m_owner = 3; m_ena = 1'b1; m_dir = 4'b0000; m_left = FT; clr = 1'b1;
        end else begin
            case (m_owner)
                0: if (onehot(k)) begin
                       m_owner = 1; m_dir = k;
                   end else if (m_pend) begin
                       m_owner = 2; m_left = BH; m_dir = m_cmd; m_btdir = m_cmd; clr = 1'b1;
                   end else m_dir = 4'b0000;
                1: if (onehot(k)) m_dir = rev_gap(k);
                   else begin m_owner = 0; m_dir = 4'b0000; end
                2: if (onehot(k)) begin
                       m_owner = 1; m_dir = rev_gap(k);
                   end else if (m_pend) begin
                       m_left = BH; m_btdir = m_cmd; m_dir = rev_gap(m_cmd); clr = 1'b1;
                   end else if (m_left == 0) begin
                       m_owner = 0; m_dir = 4'b0000;
                   end else begin
                       m_left--; m_dir = m_btdir;
                   end
                3: if (m_left > 0) m_left--;
                   else if (bus.collide) begin m_left = FT; clr = 1'b1; end
                   else begin m_owner = 0; m_ena = 1'b0; end
                default: m_owner = 0;
            endcase
        end
    endtask

    task automatic model_edge();
        bit clr;
        clr    = 1'b0;
        framed = 1'b0;
        if (m_cnt == PER - 1) begin
            frame_update(clr);
            framed = 1'b1;
        end
        if (bus.bt_valid && onehot(bus.bt_dir)) begin
            m_pend = 1'b1; m_cmd = bus.bt_dir;
        end else if (clr) m_pend = 1'b0;
        m_cnt = (m_cnt + 1) % PER;
    endtask

    task automatic compare_all();
        check("tick",  8'(bus.tick),  8'(m_cnt == PER - 1));
        check("dir",   8'(bus.dir),   8'(m_dir));
        check("ena",   8'(bus.ena),   8'(m_ena));
        check("owner", 8'(bus.owner), 8'(m_owner));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!framed && k < 2 * PER);
        check("frame_seen", 8'(framed), 8'd1);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] d, input logic e, input logic [1:0] o);
        check({tag, "_dir"},   8'(bus.dir),   8'(d));
        check({tag, "_ena"},   8'(bus.ena),   8'(e));
        check({tag, "_owner"}, 8'(bus.owner), 8'(o));
    endtask

    task automatic bt_pulse(input logic [3:0] d);
        bus.bt_dir = d; bus.bt_valid = 1'b1;
        cyc();
        bus.bt_valid = 1'b0;
    endtask

    logic [3:0] ktab [7] = '{4'b0000, 4'b1000, 4'b0001, 4'b0100, 4'b0010, 4'b1100, 4'b0000};

    initial begin
        int nt;
        rst = 1'b1;
        bus.kbd_dir = 4'b0000; bus.bt_dir = 4'b0000; bus.bt_valid = 1'b0; bus.collide = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk) rst = 1'b0;

        // Idle: four ticks in 64 clk, nothing granted.
        nt = 0;
        repeat (64) begin
            cyc();
            if (bus.tick) nt++;
        end
        check("idle_ticks", 8'(nt), 8'd4);

        // Keyboard: left three frames, then right, then release.
        bus.kbd_dir = 4'b1000;
        repeat (3) begin wait_frame(); expect_out("kbd_left", 4'b1000, 1'b0, 2'b01); end
        bus.kbd_dir = 4'b0001;
`ifdef REVERSE_GAP_EN
        wait_frame(); expect_out("kbd_gap", 4'b0000, 1'b0, 2'b01);
`endif
        wait_frame(); expect_out("kbd_right", 4'b0001, 1'b0, 2'b01);
        bus.kbd_dir = 4'b0000;
        wait_frame(); expect_out("kbd_rel", 4'b0000, 1'b0, 2'b00);

        // Bluetooth single command: grant + BH hold frames.
        bt_pulse(4'b0100);
        repeat (BH + 1) begin wait_frame(); expect_out("bt_hold", 4'b0100, 1'b0, 2'b10); end
        wait_frame(); expect_out("bt_end", 4'b0000, 1'b0, 2'b00);
        bt_pulse(4'b0110);
        repeat (2) begin wait_frame(); expect_out("bt_inval", 4'b0000, 1'b0, 2'b00); end

        // Keyboard preempts Bluetooth; BT does not resume afterwards.
        bt_pulse(4'b0010);
        wait_frame(); expect_out("bt_down", 4'b0010, 1'b0, 2'b10);
        bus.kbd_dir = 4'b0001;
        wait_frame(); expect_out("preempt", 4'b0001, 1'b0, 2'b01);
        bus.kbd_dir = 4'b0000;
        repeat (2) begin wait_frame(); expect_out("no_resume", 4'b0000, 1'b0, 2'b00); end

        // Collision in KBD: entry + FT frozen frames.
        bus.kbd_dir = 4'b1000;
        wait_frame();
        bus.collide = 1'b1;
        wait_frame(); expect_out("frz_entry", 4'b0000, 1'b1, 2'b11);
        bus.collide = 1'b0;
        repeat (FT) begin wait_frame(); expect_out("frz_hold", 4'b0000, 1'b1, 2'b11); end
        wait_frame(); expect_out("frz_exit", 4'b0000, 1'b0, 2'b00);
        bus.collide = 1'b1;
        repeat (3 * (FT + 1)) begin wait_frame(); expect_out("frz_held", 4'b0000, 1'b1, 2'b11); end
        bus.collide = 1'b0; bus.kbd_dir = 4'b0000;
        repeat (FT + 2) wait_frame();

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 11) == 0) bus.kbd_dir = ktab[$urandom_range(0, 6)];
            bus.bt_dir   = 4'($urandom_range(0, 15));
            bus.bt_valid = ($urandom_range(0, 23) == 0);
            if ($urandom_range(0, 63) == 0) bus.collide = ~bus.collide;
            cyc();
        end
        bus.bt_valid = 1'b0; bus.collide = 1'b0; bus.kbd_dir = 4'b0000;
        repeat (FT + BH + 4) wait_frame();

        // Asynchronous reset in the middle of a BT hold.
        bt_pulse(4'b0100);
        repeat (2) wait_frame();
        expect_out("pre_rst", 4'b0100, 1'b0, 2'b10);
        repeat (5) cyc();
        #2 rst = 1'b1;
        #1;
        model_reset();
        expect_out("async_rst", 4'b0000, 1'b0, 2'b00);
        check("async_rst_tick", 8'(bus.tick), 8'd0);
        @(negedge clk) rst = 1'b0;
        // Counter restarts at 0, so tick is high in the 16th cycle (after 15 edges).
        nt = 0;
        do begin
            cyc();
            nt++;
        end while (!bus.tick && nt < 3 * PER);
        check("first_tick_edges", 8'(nt), 8'(PER - 1));
        wait_frame(); expect_out("after_rst", 4'b0000, 1'b0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
